twoscomp_conv_scheduler: RTL and testbench
==========================================

// Module: twoscomp_conv_scheduler
// PURPOSE
//  Shares one sign-to-two's-complement conversion datapath (XOR-with-sign, then add sign as carry)
//  between N_REQ requesters. Round-robin arbitration, one conversion in flight,
//  registered result with valid/ready output handshake. Sits between operand producers
//  and signed arithmetic consumers.
// PARAMETERS
//  NO_BITS  10  operand/result width
//  N_REQ    4   number of requesters (>=2)
//  ID_W     2   requester-index width, clog2(N_REQ)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous, active-high reset
//  req        in   N_REQ          per-requester request; held until its gnt
//  data_in    in   N_REQ*NO_BITS  requester k operand at [k*NO_BITS +: NO_BITS]
//  sign_in    in   N_REQ          per-requester sign (1 = negate)
//  gnt        out  N_REQ          one-hot, one-cycle accept pulse
//  out_data   out  NO_BITS        converted result
//  out_id     out  ID_W           index of requester that owns out_data
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts when out_valid && out_ready
//  out_ovf    out  1              negation overflow (only with CONV_OVF_DETECT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0. out_valid, out_data, out_id and out_ovf are 0. gnt is 0.
//  FSM states:
//   IDLE: if |req, pick first set bit at or after rr_ptr (wrapping N_REQ-1 -> 0).
//         Assert gnt[k] combinationally this cycle. Capture operand, sign and k.
//         Set rr_ptr <= (k==N_REQ-1) ? 0 : k+1. Go to CONV. With no req: stay, gnt=0.
//   CONV: result = (op ^ {NO_BITS{sign}}) + sign, truncated to NO_BITS.
//         Register result into out_data and k into out_id. Set out_valid <= 1. Go to HOLD.
//   HOLD: out_valid=1. out_data and out_id stay stable.
//         On out_ready: out_valid <= 0, go to IDLE. No gnt in CONV or HOLD.
//  Latency: gnt in cycle T -> out_valid at T+2. Minimum 3 cycles per conversion.
//  req deasserted before gnt: request is withdrawn; no state change.
//  req stays high after gnt: treated as a new request at the next IDLE.
//  sign=0 passes the operand unchanged. op=0 with sign=1 gives 0.
//  rst in any state: all state, outputs and rr_ptr return to reset values next edge.
//   An in-flight result is dropped.
// CONFIGURATION
//  CONV_OVF_DETECT_EN defined: out_ovf is registered with out_data.
//   out_ovf = sign & op[NO_BITS-1] & ~|op[NO_BITS-2:0] (negating the most negative value).
//  CONV_OVF_DETECT_EN undefined: out_ovf tied to 0 and the detect logic is absent.
//   All other behaviour is identical.
// STRUCTURE
//  Shared package conv_sched_pkg: FSM state encoding (IDLE, CONV, HOLD), ID width helper.
//  Sub-module rr_picker: req and rr_ptr in; one-hot gnt and encoded index out; combinational.
//  Conversion datapath: one shared XOR bank plus adder, fed from the captured operand register.
// TESTING  (NO_BITS=10, N_REQ=4)
//  req=0001, a=10'd5, sign=1, out_ready=1 -> gnt=0001 at T.
//   At T+2: out_data=10'h3FB, out_id=0, out_valid=1 for one cycle.
//  req=0100, a=10'd37, sign=0 -> out_data=10'd37, out_id=2.
//  req=1111 held constantly, rr_ptr=0 -> grants in order 0,1,2,3,0.
//   Each grant is exactly 3 cycles apart.
//  out_ready low for 5 cycles in HOLD -> out_data, out_id and out_valid stable. gnt stays 0000.
//  rst pulsed during CONV -> next cycle: out_valid=0, gnt=0, rr_ptr=0.
//   A fresh req=0010 is then granted normally.
//  a=10'h200, sign=1 -> out_data=10'h200.
//   out_ovf=1 with CONV_OVF_DETECT_EN, 0 without.

Source files
------------

// File: rtl/twoscomp_conv_scheduler_pkg.sv
// Shared definitions for the two's-complement conversion scheduler.
//   - FSM state encoding (IDLE, CONV, HOLD)
//   - default widths and a requester-index width helper
// No ports (package).
package conv_sched_pkg;

    localparam int DEF_NO_BITS = 10;
    localparam int DEF_N_REQ   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/twoscomp_conv_scheduler_if.sv
// Handshake/bus bundle between requesters, the scheduler and the result consumer.
//   req/data_in/sign_in/gnt : requester side (data_in packs requester k at [k*NO_BITS +: NO_BITS])
//   out_*                   : result side with valid/ready handshake
// Modports: master = producers/consumer (testbench side), slave = scheduler.
interface twoscomp_conv_scheduler_if #(
    parameter int NO_BITS = 10,
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*NO_BITS-1:0] data_in;
    logic [N_REQ-1:0]         sign_in;
    logic [N_REQ-1:0]         gnt;
    logic [NO_BITS-1:0]       out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_ovf;

    modport master (
        output req, data_in, sign_in, out_ready,
        input  gnt, out_data, out_id, out_valid, out_ovf
    );

    modport slave (
        input  req, data_in, sign_in, out_ready,
        output gnt, out_data, out_id, out_valid, out_ovf
    );
endinterface

// File: rtl/twoscomp_conv_scheduler_rr_picker.sv
// Round-robin picker (purely combinational).
//   i_req  : per-requester request
//   i_ptr  : index with highest priority this cycle
//   o_gnt  : one-hot winner (0 when no request)
//   o_idx  : encoded winner index
//   o_any  : at least one request present
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_cand;

    // Scan starting at i_ptr, wrapping past N_REQ-1; first hit wins.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(N_REQ))
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            w_cand = w_sum[ID_W-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end
endmodule

// File: rtl/twoscomp_conv_scheduler.sv
// Shared sign-magnitude-to-two's-complement conversion scheduler.
// N_REQ requesters are arbitrated round-robin; one conversion is in flight at a
// time; the result is registered and offered with a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : twoscomp_conv_scheduler_if.slave (req/data_in/sign_in/gnt,
//              out_data/out_id/out_valid/out_ready/out_ovf)
// Optional feature macro: CONV_OVF_DETECT_EN -- when defined, out_ovf flags
// negation of the most negative value; otherwise out_ovf is tied to 0.
module twoscomp_conv_scheduler
    import conv_sched_pkg::*;
#(
    parameter int NO_BITS = DEF_NO_BITS,
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ID_W    = id_width(DEF_N_REQ)
) (
    input logic clk,
    input logic rst,
    twoscomp_conv_scheduler_if.slave bus
);
    state_t             r_state, w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [NO_BITS-1:0] r_op;
    logic               r_sign;
    logic [ID_W-1:0]    r_id;
    logic [NO_BITS-1:0] r_out_data;
    logic [ID_W-1:0]    r_out_id;
    logic               r_out_valid;

    logic [N_REQ-1:0]   w_pick_oh;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_any;
    logic               w_grant;
    logic [NO_BITS-1:0] w_res;

    rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_picker (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_oh),
        .o_idx (w_pick_idx),
        .o_any (w_any)
    );

    // Single shared datapath: conditional invert, then add the sign as carry-in.
    assign w_res = (r_op ^ {NO_BITS{r_sign}}) + {{(NO_BITS-1){1'b0}}, r_sign};

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_grant = 1'b1;
                w_next  = S_CONV;
            end
            S_CONV: w_next = S_HOLD;
            S_HOLD: if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grant only exists in IDLE, so it is a single-cycle pulse per acceptance.
    assign bus.gnt = w_grant ? w_pick_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_op        <= '0;
            r_sign      <= 1'b0;
            r_id        <= '0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_op   <= bus.data_in[w_pick_idx*NO_BITS +: NO_BITS];
                r_sign <= bus.sign_in[w_pick_idx];
                r_id   <= w_pick_idx;
                r_ptr  <= (w_pick_idx == ID_W'(N_REQ-1)) ? '0 : w_pick_idx + 1'b1;
            end
            if (r_state == S_CONV) begin
                r_out_data  <= w_res;
                r_out_id    <= r_id;
                r_out_valid <= 1'b1;
            end
            if (r_state == S_HOLD && bus.out_ready)
                r_out_valid <= 1'b0;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_id    = r_out_id;
    assign bus.out_valid = r_out_valid;

`ifdef CONV_OVF_DETECT_EN
    logic r_ovf;
    // Only the most negative value has no positive counterpart.
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (r_state == S_CONV)
            r_ovf <= r_sign & r_op[NO_BITS-1] & ~|r_op[NO_BITS-2:0];
    end
    assign bus.out_ovf = r_ovf;
`else
    assign bus.out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_twoscomp_conv_scheduler.sv
module tb_twoscomp_conv_scheduler;
    localparam int NB = 10;
    localparam int NR = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic exp_ovf;

    always #5 clk = ~clk;

    twoscomp_conv_scheduler_if #(.NO_BITS(NB), .N_REQ(NR), .ID_W(IW)) bus ();

    twoscomp_conv_scheduler #(.NO_BITS(NB), .N_REQ(NR), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [NB-1:0] v, input logic s);
        bus.data_in[k*NB +: NB] = v;
        bus.sign_in[k]          = s;
    endtask

    initial begin
`ifdef CONV_OVF_DETECT_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        bus.req       = '0;
        bus.data_in   = '0;
        bus.sign_in   = '0;
        bus.out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data",  32'(bus.out_data),  0);
        chk("rst_id",    32'(bus.out_id),    0);
        chk("rst_ovf",   32'(bus.out_ovf),   0);
        chk("rst_gnt",   32'(bus.gnt),       0);
        rst = 1'b0;
        tick();

        // 5 negated on requester 0
        set_op(0, 10'd5, 1'b1);
        bus.req = 4'b0001;
        #1 chk("a_gnt", 32'(bus.gnt), 32'b0001);
        tick(); bus.req = '0;
        chk("a_conv_valid", 32'(bus.out_valid), 0);
        chk("a_conv_gnt",   32'(bus.gnt), 0);
        tick();
        chk("a_valid", 32'(bus.out_valid), 1);
        chk("a_data",  32'(bus.out_data), 32'h3FB);
        chk("a_id",    32'(bus.out_id), 0);
        tick();
        chk("a_valid_drop", 32'(bus.out_valid), 0);

        // 37 passed through on requester 2
        set_op(2, 10'd37, 1'b0);
        bus.req = 4'b0100;
        #1 chk("b_gnt", 32'(bus.gnt), 32'b0100);
        tick(); bus.req = '0;
        tick();
        chk("b_data", 32'(bus.out_data), 37);
        chk("b_id",   32'(bus.out_id), 2);
        tick();

        // Round-robin from pointer 0 with all requests held
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < NR; k++) set_op(k, NB'(k + 1), 1'b0);
        bus.req = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("rr_gnt%0d", n), 32'(bus.gnt), 32'(1 << (n % 4)));
            tick();
            chk($sformatf("rr_gap%0d", n), 32'(bus.gnt), 0);
            tick();
            chk($sformatf("rr_id%0d", n),   32'(bus.out_id), 32'(n % 4));
            chk($sformatf("rr_data%0d", n), 32'(bus.out_data), 32'((n % 4) + 1));
            chk($sformatf("rr_gap2_%0d", n), 32'(bus.gnt), 0);
            if (n == 4) bus.req = '0;
            tick();
        end

        // Back-pressure: result held stable for 5 cycles, no grants
        set_op(1, 10'h155, 1'b1);
        bus.out_ready = 1'b0;
        bus.req = 4'b0010;
        #1 chk("st_gnt", 32'(bus.gnt), 32'b0010);
        tick(); bus.req = '0;
        tick();
        chk("st_valid", 32'(bus.out_valid), 1);
        chk("st_data",  32'(bus.out_data), 32'h2AB);
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("st_hold_valid%0d", n), 32'(bus.out_valid), 1);
            chk($sformatf("st_hold_data%0d", n),  32'(bus.out_data), 32'h2AB);
            chk($sformatf("st_hold_id%0d", n),    32'(bus.out_id), 1);
            chk($sformatf("st_hold_gnt%0d", n),   32'(bus.gnt), 0);
        end
        bus.req = '0;
        bus.out_ready = 1'b1;
        tick();
        chk("st_release", 32'(bus.out_valid), 0);

        // Reset while a conversion is in CONV
        set_op(0, 10'd7, 1'b0);
        bus.req = 4'b0001;
        #1 chk("rc_gnt", 32'(bus.gnt), 32'b0001);
        tick(); bus.req = '0; rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rc_valid", 32'(bus.out_valid), 0);
        chk("rc_gnt0",  32'(bus.gnt), 0);
        chk("rc_data",  32'(bus.out_data), 0);
        tick();
        chk("rc_dropped", 32'(bus.out_valid), 0);
        // Pointer back at 0: requester 0 beats requester 3
        set_op(0, 10'h200, 1'b1);
        bus.req = 4'b1001;
        #1 chk("rc_ptr0", 32'(bus.gnt), 32'b0001);
        tick(); bus.req = '0;
        tick();
        chk("ovf_data", 32'(bus.out_data), 32'h200);
        chk("ovf_flag", 32'(bus.out_ovf), 32'(exp_ovf));
        tick();

        // Fresh request on 1: zero negated stays zero
        set_op(1, 10'd0, 1'b1);
        bus.req = 4'b0010;
        #1 chk("z_gnt", 32'(bus.gnt), 32'b0010);
        tick(); bus.req = '0;
        tick();
        chk("z_valid", 32'(bus.out_valid), 1);
        chk("z_data",  32'(bus.out_data), 0);
        chk("z_id",    32'(bus.out_id), 1);
        chk("z_ovf",   32'(bus.out_ovf), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
